// File: rtl/seq_multiplier_if.sv
// Operand/result bundle between the decode stage, the iterative multiplier and the register file.
interface seq_multiplier_if #(
  parameter int WIDTH = 16
);
  logic                 Start;
  logic [WIDTH-1:0]     OperandA;
  logic [WIDTH-1:0]     OperandB;
  logic                 SignedOp;
  logic                 Busy;
  logic                 Done;
  logic [2*WIDTH-1:0]   MulResult;
  logic                 MulRegWrite;

  modport master (
    output Start, OperandA, OperandB, SignedOp,
    input  Busy, Done, MulResult, MulRegWrite
  );

  modport slave (
    input  Start, OperandA, OperandB, SignedOp,
    output Busy, Done, MulResult, MulRegWrite
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add WIDTH x WIDTH multiplier feeding the register file's MULREG write port.
// Define SIGNED_MUL_EN to honour SignedOp (sign-magnitude conversion plus final negation).
module seq_multiplier #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic            Clock,
  input  logic            ResetN,
  seq_multiplier_if.slave mulIf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t               state;
  state_t               stateNext;
  logic                 accept;
  logic                 lastIter;

  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     accHi;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   mulResult;

  logic [WIDTH:0]       partial;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   finalResult;
  logic [WIDTH-1:0]     loadA;
  logic [WIDTH-1:0]     loadB;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    lastIter  = 1'b0;
    unique case (state)
      IDLE: if (mulIf.Start) begin
        accept    = 1'b1;
        stateNext = RUN;
      end
      RUN: if (count == LAST_ITER) begin
        lastIter  = 1'b1;
        stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Upper half plus carry; the multiplier register doubles as the low half of the accumulator.
  always_comb begin
    partial = {1'b0, accHi} + (mplier[0] ? {1'b0, mcand} : '0);
  end

  assign product = {partial[WIDTH:1], partial[0], mplier[WIDTH-1:1]};

`ifdef SIGNED_MUL_EN
  logic signA;
  logic signB;
  logic negate;

  assign signA = mulIf.SignedOp & mulIf.OperandA[WIDTH-1];
  assign signB = mulIf.SignedOp & mulIf.OperandB[WIDTH-1];
  // 0x8000 negates to itself, which is the correct unsigned magnitude.
  assign loadA = signA ? (~mulIf.OperandA + 1'b1) : mulIf.OperandA;
  assign loadB = signB ? (~mulIf.OperandB + 1'b1) : mulIf.OperandB;
  assign finalResult = negate ? (~product + 1'b1) : product;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)     negate <= 1'b0;
    else if (accept) negate <= signA ^ signB;
  end
`else
  logic unusedSignedOp;

  assign unusedSignedOp = mulIf.SignedOp;
  assign loadA          = mulIf.OperandA;
  assign loadB          = mulIf.OperandB;
  assign finalResult    = product;
`endif

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      mcand     <= '0;
      mplier    <= '0;
      accHi     <= '0;
      count     <= '0;
      mulResult <= '0;
    end else if (accept) begin
      mcand  <= loadA;
      mplier <= loadB;
      accHi  <= '0;
      count  <= '0;
    end else if (state == RUN) begin
      accHi  <= partial[WIDTH:1];
      mplier <= {partial[0], mplier[WIDTH-1:1]};
      count  <= count + 1'b1;
      if (lastIter) mulResult <= finalResult;
    end
  end

  assign mulIf.Busy        = (state != IDLE);
  assign mulIf.Done        = (state == DONE);
  assign mulIf.MulRegWrite = (state == DONE);
  assign mulIf.MulResult   = mulResult;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed vectors, expected results queued at issue, checked on Done.
module tb_seq_multiplier;
  localparam int WIDTH = 16;

  logic Clock = 1'b0;
  logic ResetN = 1'b0;

  seq_multiplier_if #(.WIDTH(WIDTH)) mulIf ();

  seq_multiplier #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .Clock (Clock),
    .ResetN(ResetN),
    .mulIf (mulIf)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] res;
    int          doneCyc;
  } exp_t;

  exp_t sb[$];
  exp_t head;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busyCnt = 0;
  bit   aborted = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every Done, tracks Busy run length.
  always @(negedge Clock) begin
    if (mulIf.Done || mulIf.MulRegWrite) begin
      check("regwrite_eq_done", {31'b0, mulIf.MulRegWrite}, {31'b0, mulIf.Done});
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h expected=no_pulse (cycle %0d)", mulIf.MulResult, cyc);
      end else begin
        head = sb.pop_front();
        check("result", mulIf.MulResult, head.res);
        check("latency", cyc, head.doneCyc);
      end
    end
    if (mulIf.Busy) busyCnt++;
    else begin
      if (busyCnt != 0 && !aborted) check("busy_cycles", busyCnt, 17);
      busyCnt = 0;
      aborted = 1'b0;
    end
  end

  task automatic doMul(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [31:0] exp);
    int n = 0;
    @(negedge Clock);
    while (mulIf.Busy && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (mulIf.Busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=busy expected=idle (cycle %0d)", cyc);
    end
    mulIf.OperandA = a;
    mulIf.OperandB = b;
    mulIf.SignedOp = s;
    mulIf.Start    = 1'b1;
    sb.push_back('{exp, cyc + 17});
    @(negedge Clock);
    mulIf.Start = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((sb.size() != 0 || mulIf.Busy) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=pending%0d expected=0 (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
  endtask

  initial begin
    int k;
    mulIf.Start    = 1'b0;
    mulIf.OperandA = '0;
    mulIf.OperandB = '0;
    mulIf.SignedOp = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset_busy", {31'b0, mulIf.Busy}, 32'd0);
    check("reset_done", {31'b0, mulIf.Done}, 32'd0);
    check("reset_regwrite", {31'b0, mulIf.MulRegWrite}, 32'd0);
    check("reset_result", mulIf.MulResult, 32'd0);
    ResetN = 1'b1;

    doMul(16'h0003, 16'h0005, 1'b0, 32'h0000000F);
    waitIdle();
    doMul(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    doMul(16'h0000, 16'h1234, 1'b0, 32'h00000000);
    waitIdle();

`ifdef SIGNED_MUL_EN
    doMul(16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF);
    doMul(16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF);
    doMul(16'h8000, 16'h8000, 1'b1, 32'h40000000);
    doMul(16'h8000, 16'h0002, 1'b1, 32'hFFFF0000);
    doMul(16'hFFFD, 16'h0003, 1'b1, 32'hFFFFFFF7);
    doMul(16'hFFFE, 16'hFFFD, 1'b1, 32'h00000006);
`else
    doMul(16'hFFFF, 16'h0001, 1'b1, 32'h0000FFFF);
    doMul(16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF);
    doMul(16'h8000, 16'h8000, 1'b1, 32'h40000000);
    doMul(16'h8000, 16'h0002, 1'b1, 32'h00010000);
    doMul(16'hFFFD, 16'h0003, 1'b1, 32'h0002FFF7);
    doMul(16'hFFFE, 16'hFFFD, 1'b1, 32'hFFFB0006);
`endif
    waitIdle();

    // Second Start sampled 5 edges after acceptance must be dropped.
    doMul(16'h0004, 16'h0005, 1'b0, 32'h00000014);
    repeat (4) @(negedge Clock);
    mulIf.OperandA = 16'h0009;
    mulIf.OperandB = 16'h0009;
    mulIf.Start    = 1'b1;
    @(negedge Clock);
    mulIf.Start = 1'b0;
    waitIdle();
    repeat (3) @(negedge Clock);
    check("result_hold", mulIf.MulResult, 32'h00000014);

    // Asynchronous reset in mid-run abandons the operation.
    doMul(16'h1111, 16'h2222, 1'b0, 32'h02468642);
    repeat (7) @(negedge Clock);
    #2;
    ResetN  = 1'b0;
    aborted = 1'b1;
    sb.delete();
    #1;
    check("abort_busy", {31'b0, mulIf.Busy}, 32'd0);
    check("abort_result", mulIf.MulResult, 32'd0);
    check("abort_done", {31'b0, mulIf.Done}, 32'd0);
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;
    repeat (20) @(negedge Clock);
    check("post_abort_result", mulIf.MulResult, 32'd0);
    doMul(16'h0007, 16'h0009, 1'b0, 32'h0000003F);
    waitIdle();

    // Start held high: back-to-back acceptances 18 edges apart.
    @(negedge Clock);
    mulIf.OperandA = 16'h0002;
    mulIf.OperandB = 16'h0003;
    mulIf.SignedOp = 1'b0;
    mulIf.Start    = 1'b1;
    k = cyc;
    sb.push_back('{32'h00000006, k + 17});
    sb.push_back('{32'h00000006, k + 35});
    while (cyc < k + 19) @(negedge Clock);
    mulIf.Start = 1'b0;
    waitIdle();

    repeat (5) @(negedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
